spi_controller: RTL and testbench
=================================

SPI_CONTROLLER -- requirements
Module: spi_controller

Interface
REQ-001: Parameter DATA_WIDTH, default 8, bits per address/RW frame and per data frame.
REQ-002: Parameter CNT_WIDTH, default 3, width of the SCLK edge counter; must satisfy 2**CNT_WIDTH >= DATA_WIDTH.
REQ-003: clk  input  1  system clock; all state updates on rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: chipSelect  input  1  conditioned chip select, active-low.
REQ-006: sclkPosEdge  input  1  single-clk pulse on each SCLK rising edge.
REQ-007: sclkNegEdge  input  1  single-clk pulse on each SCLK falling edge.
REQ-008: rwBit  input  1  shift register parallel-output bit 0; 1=read, 0=write.
REQ-009: addrLatchEnable  output  1  address latch load strobe.
REQ-010: srWriteEnable  output  1  shift register parallel-load strobe.
REQ-011: dmWriteEnable  output  1  data memory write strobe.
REQ-012: misoBufferEnable  output  1  MISO tri-state driver enable.
REQ-013: fsmState  output  3  current state encoding, for debug/verification.

Function
REQ-014: States and encodings: IDLE=0, GET_ADDR=1, LATCH_ADDR=2, READ_LOAD=3, READ_SEND=4, WRITE_GET=5, WRITE_STORE=6, DONE=7.
REQ-015: Outputs are Moore, decoded from registered state only.
REQ-016: IDLE: all strobes 0; chipSelect==0 -> GET_ADDR; counter cleared.
REQ-017: GET_ADDR: count sclkPosEdge pulses; on the pulse with count==DATA_WIDTH-1 -> LATCH_ADDR, counter cleared; otherwise count+1 per pulse.
REQ-018: LATCH_ADDR: addrLatchEnable=1 for exactly one clk; next state READ_LOAD if rwBit==1, else WRITE_GET.
REQ-019: READ_LOAD: srWriteEnable=1 for exactly one clk (memory read data is combinationally valid from latched address); -> READ_SEND.
REQ-020: READ_SEND: misoBufferEnable=1; count sclkNegEdge pulses; on pulse with count==DATA_WIDTH-1 -> DONE, counter cleared.
REQ-021: WRITE_GET: count sclkPosEdge pulses; on pulse with count==DATA_WIDTH-1 -> WRITE_STORE, counter cleared.
REQ-022: WRITE_STORE: dmWriteEnable=1 for exactly one clk; -> DONE.
REQ-023: DONE: all strobes 0; sclk pulses ignored; remains until chipSelect==1.
REQ-024: In every non-IDLE state, chipSelect==1 -> IDLE next clk, counter cleared, highest priority over all other transitions.
REQ-025: chipSelect deasserted in WRITE_GET or earlier -> no dmWriteEnable pulse issued for that transaction.
REQ-026: sclkPosEdge in READ_SEND and sclkNegEdge in GET_ADDR/WRITE_GET are ignored by the counter.
REQ-027: sclkPosEdge and sclkNegEdge asserted in the same clk: each counted only in its own counting state; no double count.
REQ-028: Counter never exceeds DATA_WIDTH-1; wraps to 0 only via the transitions above.
REQ-029: At most one of addrLatchEnable, srWriteEnable, dmWriteEnable, misoBufferEnable is 1 in any clk.
REQ-030: New transaction requires a return through IDLE (chipSelect high for >=1 clk).

Reset
REQ-031: reset==1 at a clk edge -> state IDLE, counter 0, all strobes 0, fsmState=0, regardless of any other input.
REQ-032: Reset mid-transaction aborts it; no strobe asserted in the clk following reset.
REQ-033: After reset release, chipSelect already low -> GET_ADDR on the next clk edge.

Verification
REQ-034: Write: CS low, 8 posedges with rwBit=0 at byte end, 8 more posedges -> one-clk addrLatchEnable, then one-clk dmWriteEnable after 16th posedge, fsmState=7; CS high -> fsmState=0.
REQ-035: Read: CS low, 8 posedges with rwBit=1 -> addrLatchEnable one clk, srWriteEnable next clk, misoBufferEnable high until 8th negedge, then 0, fsmState=7.
REQ-036: CS raised after 5th posedge of data byte in write -> fsmState=0 next clk, dmWriteEnable never asserted.
REQ-037: reset pulsed during READ_SEND after 3 negedges -> misoBufferEnable=0 and fsmState=0 next clk; fresh read then completes normally with 8 full negedges.
REQ-038: Posedge and negedge pulses in same clk during GET_ADDR (x8) -> LATCH_ADDR after exactly 8 posedges; extra sclk pulses in DONE -> no strobes.
REQ-039: Every scenario: one-hot-or-zero check on the four strobes every clk.

Source files
------------

// File: rtl/spi_controller.sv
// SPI slave transaction sequencer.
// Tracks one chip-select framed transaction: an address/RW frame, then either a
// read (load shift register, drive MISO for one frame) or a write (collect one
// frame, then strobe the data memory). All strobes are decoded from the state
// register alone, so they are glitch-free and last exactly one state dwell.
module spi_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       chipSelect,
    input  logic       sclkPosEdge,
    input  logic       sclkNegEdge,
    input  logic       rwBit,
    output logic       addrLatchEnable,
    output logic       srWriteEnable,
    output logic       dmWriteEnable,
    output logic       misoBufferEnable,
    output logic [2:0] fsmState
);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] GET_ADDR    = 3'd1;
    localparam logic [2:0] LATCH_ADDR  = 3'd2;
    localparam logic [2:0] READ_LOAD   = 3'd3;
    localparam logic [2:0] READ_SEND   = 3'd4;
    localparam logic [2:0] WRITE_GET   = 3'd5;
    localparam logic [2:0] WRITE_STORE = 3'd6;
    localparam logic [2:0] DONE        = 3'd7;

    // Count value seen on the edge pulse that completes a frame.
    localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(DATA_WIDTH - 1);

    logic [2:0]           stateReg;
    logic [2:0]           stateNext;
    logic [CNT_WIDTH-1:0] countReg;
    logic [CNT_WIDTH-1:0] countNext;

    // Next-state and edge-counter logic; chip-select release aborts from anywhere.
    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        if (stateReg != IDLE && chipSelect) begin
            stateNext = IDLE;
            countNext = '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    countNext = '0;
                    if (!chipSelect) begin
                        stateNext = GET_ADDR;
                    end
                end
                GET_ADDR: begin
                    // Only rising SCLK edges sample MOSI; falling edges are ignored here.
                    if (sclkPosEdge) begin
                        if (countReg == LAST_COUNT) begin
                            stateNext = LATCH_ADDR;
                            countNext = '0;
                        end else begin
                            countNext = countReg + 1'b1;
                        end
                    end
                end
                LATCH_ADDR: begin
                    countNext = '0;
                    stateNext = rwBit ? READ_LOAD : WRITE_GET;
                end
                READ_LOAD: begin
                    stateNext = READ_SEND;
                end
                READ_SEND: begin
                    // MISO shifts out on falling SCLK edges.
                    if (sclkNegEdge) begin
                        if (countReg == LAST_COUNT) begin
                            stateNext = DONE;
                            countNext = '0;
                        end else begin
                            countNext = countReg + 1'b1;
                        end
                    end
                end
                WRITE_GET: begin
                    if (sclkPosEdge) begin
                        if (countReg == LAST_COUNT) begin
                            stateNext = WRITE_STORE;
                            countNext = '0;
                        end else begin
                            countNext = countReg + 1'b1;
                        end
                    end
                end
                WRITE_STORE: begin
                    stateNext = DONE;
                end
                DONE: begin
                    // Hold here, ignoring SCLK, until chip select goes high.
                    stateNext = DONE;
                end
                default: begin
                    stateNext = IDLE;
                    countNext = '0;
                end
            endcase
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg <= IDLE;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
        end
    end

    // Moore output decode: each strobe belongs to exactly one state, so at most one is high.
    always_comb begin
        addrLatchEnable  = (stateReg == LATCH_ADDR);
        srWriteEnable    = (stateReg == READ_LOAD);
        dmWriteEnable    = (stateReg == WRITE_STORE);
        misoBufferEnable = (stateReg == READ_SEND);
        fsmState         = stateReg;
    end

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: a negedge monitor turns strobe
// activity into events and checks them against a queue of expected events
// pushed by each scenario; direct checks cover state and MISO timing.
module tb_spi_controller;

    localparam int DW = 8;

    localparam int EV_NONE     = 0;
    localparam int EV_ALE      = 1;
    localparam int EV_SRWE     = 2;
    localparam int EV_DMWE     = 3;
    localparam int EV_MISO_ON  = 4;
    localparam int EV_MISO_OFF = 5;

    logic       clk;
    logic       reset;
    logic       chipSelect;
    logic       sclkPosEdge;
    logic       sclkNegEdge;
    logic       rwBit;
    logic       addrLatchEnable;
    logic       srWriteEnable;
    logic       dmWriteEnable;
    logic       misoBufferEnable;
    logic [2:0] fsmState;

    int compareCount  = 0;
    int mismatchCount = 0;
    int expQ[$];
    bit monitorOn = 0;
    bit misoPrev  = 0;

    spi_controller #(.DATA_WIDTH(DW), .CNT_WIDTH(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .chipSelect      (chipSelect),
        .sclkPosEdge     (sclkPosEdge),
        .sclkNegEdge     (sclkNegEdge),
        .rwBit           (rwBit),
        .addrLatchEnable (addrLatchEnable),
        .srWriteEnable   (srWriteEnable),
        .dmWriteEnable   (dmWriteEnable),
        .misoBufferEnable(misoBufferEnable),
        .fsmState        (fsmState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input int observed, input int expected);
        compareCount++;
        if (observed != expected) begin
            mismatchCount++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Pop the next expected event (EV_NONE when none is pending) and compare.
    task automatic expectEvent(input string tag, input int ev);
        int want;
        want = (expQ.size() > 0) ? expQ.pop_front() : EV_NONE;
        checkValue(tag, ev, want);
    endtask

    // Monitor: one-hot-or-zero check every clk plus strobe events to the scoreboard.
    always @(negedge clk) begin
        if (monitorOn) begin
            checkValue("strobe_onehot",
                       int'($countones({addrLatchEnable, srWriteEnable, dmWriteEnable, misoBufferEnable}) <= 1), 1);
            if (addrLatchEnable)               expectEvent("ev_ale", EV_ALE);
            if (srWriteEnable)                 expectEvent("ev_srwe", EV_SRWE);
            if (dmWriteEnable)                 expectEvent("ev_dmwe", EV_DMWE);
            if (misoBufferEnable && !misoPrev) expectEvent("ev_miso_on", EV_MISO_ON);
            if (!misoBufferEnable && misoPrev) expectEvent("ev_miso_off", EV_MISO_OFF);
            misoPrev = misoBufferEnable;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sclkPulse(input logic pos, input logic neg);
        sclkPosEdge = pos;
        sclkNegEdge = neg;
        tick();
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        tick();
    endtask

    task automatic startTxn();
        chipSelect = 1'b0;
        tick();
        checkValue("start_get_addr", fsmState, 1);
    endtask

    // Address frame; bothEdges drives posedge and negedge in the same clk.
    task automatic sendAddress(input logic rw, input bit bothEdges);
        rwBit = rw;
        for (int i = 0; i < DW; i++) begin
            if (i == DW - 1) checkValue("addr_still_counting", fsmState, 1);
            sclkPulse(1'b1, bothEdges);
        end
        checkValue("after_latch", fsmState, rw ? 3 : 5);
    endtask

    task automatic readData();
        tick();
        checkValue("read_send_state", fsmState, 4);
        checkValue("miso_on", misoBufferEnable, 1);
        for (int i = 0; i < DW; i++) begin
            if (i == 3) sclkPulse(1'b1, 1'b0);
            if (i == DW - 1) checkValue("miso_before_last", misoBufferEnable, 1);
            sclkPulse(1'b0, 1'b1);
        end
        checkValue("miso_off_after_last", misoBufferEnable, 0);
        checkValue("read_done", fsmState, 7);
    endtask

    task automatic writeData(input bit bothEdges);
        for (int i = 0; i < DW; i++) begin
            if (i == DW - 1) checkValue("wdata_counting", fsmState, 5);
            sclkPulse(1'b1, bothEdges);
        end
        checkValue("write_done", fsmState, 7);
    endtask

    task automatic endTxn();
        chipSelect = 1'b1;
        tick();
        checkValue("cs_high_idle", fsmState, 0);
        tick();
        checkValue("scoreboard_empty", expQ.size(), 0);
    endtask

    initial begin
        reset       = 1'b1;
        chipSelect  = 1'b0;
        sclkPosEdge = 1'b1;
        sclkNegEdge = 1'b1;
        rwBit       = 1'b1;
        tick();
        tick();
        checkValue("reset_state", fsmState, 0);
        checkValue("reset_strobes",
                   int'({addrLatchEnable, srWriteEnable, dmWriteEnable, misoBufferEnable}), 0);
        reset       = 1'b0;
        chipSelect  = 1'b1;
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
        tick();
        checkValue("idle_after_release", fsmState, 0);
        monitorOn = 1;

        // Write transaction.
        startTxn();
        expQ.push_back(EV_ALE);
        expQ.push_back(EV_DMWE);
        sendAddress(1'b0, 0);
        writeData(0);
        endTxn();
        $display("txn write: compared=%0d mismatched=%0d", compareCount, mismatchCount);

        // Read transaction, with a stray posedge during the send phase.
        startTxn();
        expQ.push_back(EV_ALE);
        expQ.push_back(EV_SRWE);
        expQ.push_back(EV_MISO_ON);
        expQ.push_back(EV_MISO_OFF);
        sendAddress(1'b1, 0);
        readData();
        endTxn();
        $display("txn read: compared=%0d mismatched=%0d", compareCount, mismatchCount);

        // Write aborted after 5 data posedges: no data memory strobe.
        startTxn();
        expQ.push_back(EV_ALE);
        sendAddress(1'b0, 0);
        for (int i = 0; i < 5; i++) sclkPulse(1'b1, 1'b0);
        chipSelect = 1'b1;
        tick();
        checkValue("abort_idle", fsmState, 0);
        repeat (3) tick();
        checkValue("abort_scoreboard_empty", expQ.size(), 0);
        $display("txn write_abort: compared=%0d mismatched=%0d", compareCount, mismatchCount);

        // Reset during READ_SEND, then a fresh read straight out of reset.
        startTxn();
        expQ.push_back(EV_ALE);
        expQ.push_back(EV_SRWE);
        expQ.push_back(EV_MISO_ON);
        expQ.push_back(EV_MISO_OFF);
        sendAddress(1'b1, 0);
        tick();
        for (int i = 0; i < 3; i++) sclkPulse(1'b0, 1'b1);
        checkValue("pre_reset_miso", misoBufferEnable, 1);
        reset = 1'b1;
        tick();
        checkValue("mid_reset_miso", misoBufferEnable, 0);
        checkValue("mid_reset_state", fsmState, 0);
        reset = 1'b0;
        tick();
        checkValue("post_reset_get_addr", fsmState, 1);
        expQ.push_back(EV_ALE);
        expQ.push_back(EV_SRWE);
        expQ.push_back(EV_MISO_ON);
        expQ.push_back(EV_MISO_OFF);
        sendAddress(1'b1, 0);
        readData();
        endTxn();
        $display("txn read_reset: compared=%0d mismatched=%0d", compareCount, mismatchCount);

        // Both edge pulses in the same clk, then extra pulses while DONE.
        startTxn();
        expQ.push_back(EV_ALE);
        expQ.push_back(EV_DMWE);
        sendAddress(1'b0, 1);
        writeData(1);
        for (int i = 0; i < 4; i++) sclkPulse(1'b1, 1'b1);
        checkValue("done_ignores_sclk", fsmState, 7);
        endTxn();
        $display("txn write_bothedges: compared=%0d mismatched=%0d", compareCount, mismatchCount);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
